// File: rtl/pe_job_ctrl_if.sv
// Stream bundle between the job controller, the GLB mover, the PE and the opsum sink.
// master is the controller side; slave is the environment side.
interface pe_job_ctrl_if #(
   parameter int CONFIG_SIZE = 13,
   parameter int DATA_BITS   = 32
);
   logic [DATA_BITS-1:0]   src_data;
   logic                   src_valid;
   logic                   src_ready;

   logic                   pe_en;
   logic [CONFIG_SIZE-1:0] pe_config;
   logic [DATA_BITS-1:0]   pe_data;

   logic                   pe_filter_valid;
   logic                   pe_ifmap_valid;
   logic                   pe_dw_ipsum_valid;
   logic                   pe_pw_ipsum_valid;
   logic                   pe_filter_ready;
   logic                   pe_ifmap_ready;
   logic                   pe_dw_ipsum_ready;
   logic                   pe_pw_ipsum_ready;

   logic [DATA_BITS-1:0]   pe_opsum;
   logic                   pe_opsum_valid;
   logic                   pe_opsum_ready;

   logic [DATA_BITS-1:0]   dst_data;
   logic                   dst_valid;
   logic                   dst_ready;

   modport master (
      input  src_data, src_valid,
      output src_ready,
      output pe_en, pe_config, pe_data,
      output pe_filter_valid, pe_ifmap_valid,
      output pe_dw_ipsum_valid, pe_pw_ipsum_valid,
      input  pe_filter_ready, pe_ifmap_ready,
      input  pe_dw_ipsum_ready, pe_pw_ipsum_ready,
      input  pe_opsum, pe_opsum_valid,
      output pe_opsum_ready,
      output dst_data, dst_valid,
      input  dst_ready
   );

   modport slave (
      output src_data, src_valid,
      input  src_ready,
      input  pe_en, pe_config, pe_data,
      input  pe_filter_valid, pe_ifmap_valid,
      input  pe_dw_ipsum_valid, pe_pw_ipsum_valid,
      output pe_filter_ready, pe_ifmap_ready,
      output pe_dw_ipsum_ready, pe_pw_ipsum_ready,
      output pe_opsum, pe_opsum_valid,
      input  pe_opsum_ready,
      input  dst_data, dst_valid,
      output dst_ready
   );
endinterface

// File: rtl/pe_job_ctrl.sv
// Single-PE job sequencer: config pulse, input phase routing,
// opsum forwarding and output-column looping.
module pe_job_ctrl #(
   parameter int CONFIG_SIZE = 13,
   parameter int DATA_BITS   = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [CONFIG_SIZE-1:0] cfg,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [2:0]             phase,
   output logic [4:0]             col_idx,
   pe_job_ctrl_if.master          bus
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CFG      = 3'd1,
      S_FILTER   = 3'd2,
      S_IFMAP    = 3'd3,
      S_DW_IPSUM = 3'd4,
      S_PW_IPSUM = 3'd5,
      S_OPSUM    = 3'd6,
      S_DONE     = 3'd7
   } state_e;

   state_e                 state_q, state_d;
   logic [CONFIG_SIZE-1:0] cfg_q, cfg_d;
   logic [4:0]             col_q, col_d;
   logic [4:0]             cnt_q, cnt_d;
   logic                   err_q, err_d;

   logic [4:0] p_w, q_w, rs_w, filt_w, need_w;
   logic       dw_w, beat_w, last_w;

   // Derived job geometry; p*rs tops out at 16, so 5 bits hold it.
   assign dw_w   = cfg_q[12];
   assign p_w    = {3'b000, cfg_q[8:7]} + 5'd1;
   assign q_w    = {3'b000, cfg_q[1:0]} + 5'd1;
   assign rs_w   = {3'b000, cfg_q[11:10]} + 5'd1;
   assign filt_w = p_w * rs_w;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cfg_q   <= '0;
         col_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
         col_q   <= col_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Routing: the active phase owns the shared source stream.
   always_comb begin
      need_w                 = 5'd1;
      beat_w                 = 1'b0;
      bus.src_ready          = 1'b0;
      bus.pe_filter_valid    = 1'b0;
      bus.pe_ifmap_valid     = 1'b0;
      bus.pe_dw_ipsum_valid  = 1'b0;
      bus.pe_pw_ipsum_valid  = 1'b0;
      bus.pe_opsum_ready     = 1'b0;
      bus.dst_valid          = 1'b0;
      bus.dst_data           = {DATA_BITS{1'b0}};
      unique case (state_q)
         S_FILTER: begin
            need_w              = filt_w;
            bus.pe_filter_valid = bus.src_valid;
            bus.src_ready       = bus.pe_filter_ready;
            beat_w = bus.src_valid & bus.pe_filter_ready;
         end
         S_IFMAP: begin
            need_w             = (col_q == 5'd0) ? rs_w : 5'd1;
            bus.pe_ifmap_valid = bus.src_valid;
            bus.src_ready      = bus.pe_ifmap_ready;
            beat_w = bus.src_valid & bus.pe_ifmap_ready;
         end
         S_DW_IPSUM: begin
            need_w                = dw_w ? q_w : p_w;
            bus.pe_dw_ipsum_valid = bus.src_valid;
            bus.src_ready         = bus.pe_dw_ipsum_ready;
            beat_w = bus.src_valid & bus.pe_dw_ipsum_ready;
         end
         S_PW_IPSUM: begin
            need_w                = p_w;
            bus.pe_pw_ipsum_valid = bus.src_valid;
            bus.src_ready         = bus.pe_pw_ipsum_ready;
            beat_w = bus.src_valid & bus.pe_pw_ipsum_ready;
         end
         S_OPSUM: begin
            need_w             = p_w;
            bus.dst_data       = bus.pe_opsum;
            bus.dst_valid      = bus.pe_opsum_valid;
            bus.pe_opsum_ready = bus.dst_ready;
            beat_w = bus.pe_opsum_valid & bus.dst_ready;
         end
         S_IDLE, S_CFG, S_DONE: begin
            need_w = 5'd1;
         end
      endcase
   end

   assign last_w = beat_w & (cnt_q == need_w - 5'd1);

   always_comb begin
      state_d = state_q;
      cfg_d   = cfg_q;
      col_d   = col_q;
      cnt_d   = cnt_q;
      err_d   = err_q | (bus.pe_opsum_valid & (state_q != S_OPSUM));
      if (beat_w) begin
         cnt_d = last_w ? 5'd0 : cnt_q + 5'd1;
      end
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               cfg_d   = cfg;
               col_d   = 5'd0;
               cnt_d   = 5'd0;
               err_d   = 1'b0;
               state_d = S_CFG;
            end
         end
         S_CFG: state_d = S_FILTER;
         S_FILTER: begin
            if (last_w) state_d = S_IFMAP;
         end
         S_IFMAP: begin
            if (last_w) state_d = S_DW_IPSUM;
         end
         S_DW_IPSUM: begin
            if (last_w) state_d = dw_w ? S_PW_IPSUM : S_OPSUM;
         end
         S_PW_IPSUM: begin
            if (last_w) state_d = S_OPSUM;
         end
         S_OPSUM: begin
            if (last_w) begin
               if (col_q == cfg_q[6:2]) begin
                  state_d = S_DONE;
               end else begin
                  col_d   = col_q + 5'd1;
                  state_d = S_IFMAP;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
      endcase
   end

   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign err           = err_q;
   assign phase         = state_q;
   assign col_idx       = col_q;
   assign bus.pe_en     = (state_q == S_CFG);
   assign bus.pe_config = cfg_q;
   assign bus.pe_data   = bus.src_data;

endmodule

// File: doc/pe_job_ctrl.md
# pe_job_ctrl

Single-PE job sequencer for the PE array. It accepts a 13-bit PE configuration word, pulses the PE enable with that configuration, and routes one shared 32-bit global-buffer input stream to the PE's four input streams in the order the PE consumes them. It forwards PE opsums to the output sink and loops over output columns until the job completes. It sits between the GLB data mover and one PE.

## Interface
Parameters:
- `CONFIG_SIZE`, 13: config word width; field layout matches the PE config.
- `DATA_BITS`, 32: stream data width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  job request; accepted only in IDLE.
- `cfg`  in  CONFIG_SIZE  job config: [12] depthwise, [11:10] rs-1, [9] mode, [8:7] p-1, [6:2] F, [1:0] q-1.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse at job end.
- `err`  out  1  sticky protocol error.
- `phase`  out  3  current state encoding, which tells the mover what to send.
- `col_idx`  out  5  current output column.
- `src_data`  in  32  GLB word.
- `src_valid` in / `src_ready` out  1 each  GLB handshake.
- `pe_en`  out  1  PE enable.
- `pe_config`  out  CONFIG_SIZE  latched cfg.
- `pe_data`  out  32  equals src_data; fans out to the PE filter/ifmap/ipsum inputs.
- `pe_filter_valid`, `pe_ifmap_valid`, `pe_dw_ipsum_valid`, `pe_pw_ipsum_valid`  out  1 each.
- `pe_filter_ready`, `pe_ifmap_ready`, `pe_dw_ipsum_ready`, `pe_pw_ipsum_ready`  in  1 each.
- `pe_opsum`  in  32.
- `pe_opsum_valid` in / `pe_opsum_ready` out  1 each.
- `dst_data`  out  32.
- `dst_valid` out / `dst_ready` in  1 each  sink handshake.

## Operation
- **States:** IDLE=0, CFG=1, FILTER=2, IFMAP=3, DW_IPSUM=4, PW_IPSUM=5, OPSUM=6, DONE=7. `phase` equals the state encoding.
- **Start:** IDLE with `start` latches `cfg` into `pe_config`, clears `col_idx`, `err` and the beat counter, then moves to CFG.
- **CFG:** `pe_en`=1 for exactly this one cycle, then FILTER.
- **Derived values** (unsigned): p=cfg[8:7]+1, q=cfg[1:0]+1, rs=cfg[11:10]+1. Beat counter is 5 bits.
- **Beat counts per phase:**
  - FILTER: p*rs beats (1..16).
  - IFMAP: rs beats when col_idx=0, otherwise 1 beat.
  - DW_IPSUM: q beats if depthwise, otherwise p beats.
  - PW_IPSUM: p beats; entered only when depthwise.
  - OPSUM: p beats.
- **Input routing:** in input phase X, `pe_X_valid` = `src_valid` and `src_ready` = `pe_X_ready`. All other `pe_*_valid` are 0. In IDLE, CFG, OPSUM and DONE, `src_ready`=0 and all `pe_*_valid`=0.
- **Beat count:** a beat is `src_valid & src_ready`. The last beat clears the counter and advances the state.
- **Phase order:**
  - FILTER → IFMAP → DW_IPSUM.
  - DW_IPSUM → PW_IPSUM if depthwise, else OPSUM.
  - PW_IPSUM → OPSUM.
- **Opsum routing:** in OPSUM, `dst_data`=`pe_opsum`, `dst_valid`=`pe_opsum_valid`, `pe_opsum_ready`=`dst_ready`. Outside OPSUM, `dst_valid`=0 and `pe_opsum_ready`=0. A beat is `pe_opsum_valid & dst_ready`.
- **End of OPSUM** (last beat):
  - if col_idx==F: go to DONE.
  - otherwise: col_idx+1, go to IFMAP.
  - Total columns = F+1.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **err:** set when `pe_opsum_valid`=1 while state≠OPSUM. Sticky until the next accepted start. It does not alter sequencing.
- **mode** bit: passed through in `pe_config` only.

## Timing
- **Reset values:** state IDLE, every output 0 (`pe_config`=0, `phase`=0, `col_idx`=0).
- **Reset mid-job:** aborts on the next edge, with no `done` and no `pe_en`. The PE is reset separately.
- **Start latency:** `start` at edge N → CFG (`pe_en`=1) in cycle N+1 → FILTER in cycle N+2.
- **Phase advance:** the last-beat handshake in cycle k → new phase in k+1. There is no other bubble.
- **Handshake paths:** combinational pass-through in both directions; there is no buffering.
- **start while busy:** ignored, including in DONE. `cfg` changes while busy do not affect the job.
- **F=0:** single column, DONE after the first OPSUM.
- **src_valid held outside input phases:** the word is not consumed.
- **Back-pressure:** `pe_X_ready` or `dst_ready` low stalls the counter. There is no timeout.

## Test plan
- **Standard job, cfg=0x0887** (p=2, q=4, rs=3, F=1), all ready: pe_en pulse; 6 filter beats, 3 ifmap, 2 ipsum, 2 opsum; then 1 ifmap, 2 ipsum, 2 opsum; done pulse; col_idx sequence 0,1.
- **Depthwise job, cfg=0x1983** (p=4, q=4, rs=3, F=0): 12 filter, 3 ifmap, 4 dw ipsum, 4 pw ipsum, 4 opsum, then done. PW_IPSUM has `phase`=5.
- **Back-pressure:** random `pe_ifmap_ready` and `dst_ready` low on the standard job. Beat counts are unchanged, no word is dropped, and `dst_data` matches `pe_opsum` on every accepted beat.
- **Protocol checks:** start asserted during FILTER is ignored and the job completes once. `pe_opsum_valid`=1 during IFMAP sets `err`=1, which clears on the next start.
- **Reset mid-job:** `rst` asserted in DW_IPSUM gives all outputs 0 next cycle and `done` never pulses. A new start afterwards runs a full, correct job.
